imem_loader: RTL and testbench
==============================

IMEM_LOADER -- requirements
Module: imem_loader

Interface
REQ-001 Parameter DEPTH, 256, instruction-memory depth in 32-bit words.
REQ-002 Parameter ADDR_W, 8, word-address width; DEPTH SHALL equal 2**ADDR_W.
REQ-003 clk_i  input  1  single clock; all state SHALL change on its rising edge only.
REQ-004 rst_i  input  1  reset, synchronous, active-low.
REQ-005 byte_valid_i  input  1  an image byte is presented.
REQ-006 byte_data_i  input  8  image byte; words are sent little-endian.
REQ-007 byte_last_i  input  1  qualifies byte_data_i as the final byte of the image.
REQ-008 byte_ready_o  output  1  loader accepts a byte this cycle.
REQ-009 imem_we_o  output  1  instruction-memory write strobe, one word per asserted cycle.
REQ-010 imem_addr_o  output  ADDR_W  word address of the write.
REQ-011 imem_data_o  output  32  write data.
REQ-012 start_o  output  1  drives the CPU start_i input.
REQ-013 err_o  output  1  sticky load error.
REQ-014 words_o  output  ADDR_W+1  count of image words written (0..DEPTH).

Function
REQ-015 FSM states: CLEAR, LOAD, DONE, ERROR.
REQ-016 CLEAR: imem_we_o=1 every cycle; imem_addr_o steps 0..DEPTH-1; imem_data_o=0; byte_ready_o=0; after the write to DEPTH-1, go to LOAD next cycle.
REQ-017 LOAD: byte_ready_o=1; a byte is accepted only on a cycle with byte_valid_i=1 and byte_ready_o=1.
REQ-018 2-bit byte index selects the word lane: index 0 -> bits [7:0], 1 -> [15:8], 2 -> [23:16], 3 -> [31:24]; index increments on each accepted byte and wraps 3 -> 0.
REQ-019 Write latency: the cycle after the index-3 byte is accepted, imem_we_o=1 for exactly one cycle with imem_addr_o = current word counter and imem_data_o = the assembled word; the word counter and words_o increment in that same cycle.
REQ-020 Lanes are overwritten per word; no byte of a previous word SHALL leak into the next.
REQ-021 byte_last_i on an accepted index-3 byte: complete the write per REQ-019, then enter DONE the same cycle the write strobe is asserted.
REQ-022 byte_last_i on an accepted byte with index 0-2: enter ERROR next cycle; the partial word is never written.
REQ-023 Overflow: a byte accepted while words_o == DEPTH causes ERROR next cycle; no write occurs.
REQ-024 byte_last_i with byte_valid_i=0, or while byte_ready_o=0, SHALL be ignored.
REQ-025 DONE: start_o=1 held; byte_ready_o=0; imem_we_o=0; stays until reset.
REQ-026 ERROR: err_o=1 held; start_o=0; byte_ready_o=0; imem_we_o=0; stays until reset.
REQ-027 imem_we_o SHALL be 0 in every cycle not described in REQ-016 or REQ-019.
REQ-028 byte_valid_i may deassert between any two bytes; gaps SHALL NOT alter the index or the assembled word.

Reset
REQ-029 rst_i=0 at a clock edge: state=CLEAR, clear address=0, byte index=0, word counter=0, assembled word=0.
REQ-030 Output values while reset is asserted and in the first cycle after release: byte_ready_o=0, start_o=0, err_o=0, words_o=0, imem_data_o=0. imem_addr_o=0 and imem_we_o=1, with the CLEAR write of address 0 starting that cycle.
REQ-031 Reset asserted in any state, including mid-word or mid-CLEAR, aborts all activity; no partial word is written; CLEAR restarts from address 0.

Verification
REQ-032 Release reset -> 256 consecutive cycles of imem_we_o=1, addresses 0..255, data 0, byte_ready_o=0; byte_ready_o=1 on the following cycle.
REQ-033 In LOAD, send 0x13,0x05,0x50,0x00 with last on the 4th byte -> next cycle imem_we_o=1, addr 0, data 0x00500513, words_o=1; start_o=1 from the following cycle onward.
REQ-034 Send 2 words with 3-cycle valid gaps -> writes at addresses 0 and 1 with correct data; no extra strobes.
REQ-035 Send 2 bytes with last on the 2nd -> err_o=1 next cycle; no write; start_o stays 0; byte_ready_o=0.
REQ-036 Stream 256 full words without last, then 1 byte -> 256 writes, words_o=256, err_o=1 after the extra byte.
REQ-037 Assert rst_i=0 after 2 bytes of a word -> outputs reset per REQ-030; on release, CLEAR restarts at address 0; the partial word is never written.

Source files
------------

// File: rtl/imem_loader_if.sv
// rtl/imem_loader_if.sv - byte-stream input and instruction-memory write bus of the image loader
interface imem_loader_if #(
  parameter int ADDR_W = 8
);
  logic              byte_valid_i;
  logic [7:0]        byte_data_i;
  logic              byte_last_i;
  logic              byte_ready_o;
  logic              imem_we_o;
  logic [ADDR_W-1:0] imem_addr_o;
  logic [31:0]       imem_data_o;
  logic              start_o;
  logic              err_o;
  logic [ADDR_W:0]   words_o;

  // Image source and memory/CPU side
  modport master (
    output byte_valid_i, byte_data_i, byte_last_i,
    input  byte_ready_o, imem_we_o, imem_addr_o, imem_data_o, start_o, err_o, words_o
  );

  // Loader side
  modport slave (
    input  byte_valid_i, byte_data_i, byte_last_i,
    output byte_ready_o, imem_we_o, imem_addr_o, imem_data_o, start_o, err_o, words_o
  );
endinterface

// File: rtl/imem_loader.sv
// rtl/imem_loader.sv - zero-fills instruction memory, loads a little-endian byte image, then starts the CPU
module imem_loader #(
  parameter int DEPTH  = 256,
  parameter int ADDR_W = 8
) (
  input  logic          clk_i,
  input  logic          rst_i,
  imem_loader_if.slave  bus
);

  typedef enum logic [1:0] {CLEAR, LOAD, DONE, ERROR} state_t;

  localparam logic [ADDR_W:0]   FULL      = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

  state_t            state;
  logic [1:0]        idx;
  logic [ADDR_W:0]   word_cnt;
  // Lanes 0..2 of the word in progress; lane 3 goes straight into the write data
  logic [23:0]       asm_q;
  logic              we_q;
  logic [ADDR_W-1:0] addr_q;
  logic [31:0]       data_q;
  logic              ready_q;
  logic              start_q;
  logic              err_q;
  logic              accept;

  assign accept = bus.byte_valid_i && ready_q;

  assign bus.byte_ready_o = ready_q;
  assign bus.imem_we_o    = we_q;
  assign bus.imem_addr_o  = addr_q;
  assign bus.imem_data_o  = data_q;
  assign bus.start_o      = start_q;
  assign bus.err_o        = err_q;
  assign bus.words_o      = word_cnt;

  // Loader FSM: every output is a register; addr_q doubles as the clear address
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      state    <= CLEAR;
      idx      <= 2'd0;
      word_cnt <= '0;
      asm_q    <= '0;
      we_q     <= 1'b1;
      addr_q   <= '0;
      data_q   <= '0;
      ready_q  <= 1'b0;
      start_q  <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      case (state)
        CLEAR: begin
          if (addr_q == LAST_ADDR) begin
            state   <= LOAD;
            we_q    <= 1'b0;
            ready_q <= 1'b1;
          end else begin
            addr_q  <= addr_q + 1'b1;
          end
        end

        LOAD: begin
          we_q <= 1'b0;
          if (accept) begin
            if (word_cnt == FULL) begin
              // Image larger than memory: refuse the byte and stop
              state   <= ERROR;
              err_q   <= 1'b1;
              ready_q <= 1'b0;
            end else if (idx == 2'd3) begin
              we_q     <= 1'b1;
              addr_q   <= word_cnt[ADDR_W-1:0];
              data_q   <= {bus.byte_data_i, asm_q};
              word_cnt <= word_cnt + 1'b1;
              idx      <= 2'd0;
              asm_q    <= '0;
              if (bus.byte_last_i) begin
                state   <= DONE;
                ready_q <= 1'b0;
              end
            end else if (bus.byte_last_i) begin
              // Image ended mid-word: the partial word is dropped
              state   <= ERROR;
              err_q   <= 1'b1;
              ready_q <= 1'b0;
            end else begin
              case (idx)
                2'd0:    asm_q[7:0]   <= bus.byte_data_i;
                2'd1:    asm_q[15:8]  <= bus.byte_data_i;
                default: asm_q[23:16] <= bus.byte_data_i;
              endcase
              idx <= idx + 1'b1;
            end
          end
        end

        DONE: begin
          // start follows the final write by one cycle so the CPU never fetches a word still being written
          we_q    <= 1'b0;
          ready_q <= 1'b0;
          start_q <= 1'b1;
        end

        ERROR: begin
          we_q    <= 1'b0;
          ready_q <= 1'b0;
          start_q <= 1'b0;
          err_q   <= 1'b1;
        end

        default: begin
          state <= ERROR;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_imem_loader.sv
// tb/tb_imem_loader.sv - self-checking bench for imem_loader: table-driven words plus scoreboarded write stream
module tb_imem_loader;

  logic clk = 1'b0;
  logic rst = 1'b0;

  // 100 MHz clock
  always #5 clk = ~clk;

  imem_loader_if #(.ADDR_W(8)) bus ();

  imem_loader #(.DEPTH(256), .ADDR_W(8)) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus)
  );

  int n_pass  = 0;
  int n_total = 0;
  bit mon_en  = 1'b0;

  typedef struct packed {
    logic [7:0]  addr;
    logic [31:0] data;
  } wr_t;

  wr_t sb_q[$];

  typedef struct {
    logic [7:0]  b0, b1, b2, b3;
    int          gap;
    logic [31:0] exp_word;
  } vec_t;

  vec_t vec[4];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Scoreboard: every write strobe seen in LOAD must match the oldest expected write
  always @(negedge clk) begin
    if (mon_en && bus.imem_we_o === 1'b1) begin
      if (sb_q.size() == 0) begin
        n_total++;
        $display("FAIL extra_write: addr 0x%0h data 0x%0h with nothing expected", bus.imem_addr_o, bus.imem_data_o);
      end else begin
        wr_t e;
        e = sb_q.pop_front();
        check("wr_addr",  64'(bus.imem_addr_o), 64'(e.addr));
        check("wr_data",  64'(bus.imem_data_o), 64'(e.data));
        check("wr_words", 64'(bus.words_o),     64'(e.addr) + 64'd1);
      end
    end
  end

  task automatic send_byte(input logic [7:0] b, input logic last, input int gap);
    bus.byte_valid_i = 1'b1;
    bus.byte_data_i  = b;
    bus.byte_last_i  = last;
    step();
    bus.byte_valid_i = 1'b0;
    for (int g = 0; g < gap; g++) begin
      bus.byte_last_i = 1'b1;
      bus.byte_data_i = 8'($urandom);
      step();
    end
    bus.byte_last_i = 1'b0;
  endtask

  task automatic do_reset();
    mon_en           = 1'b0;
    rst              = 1'b0;
    bus.byte_valid_i = 1'b0;
    bus.byte_last_i  = 1'b0;
    bus.byte_data_i  = 8'h00;
    step();
    step();
    check("rst_we",    64'(bus.imem_we_o),    64'd1);
    check("rst_addr",  64'(bus.imem_addr_o),  64'd0);
    check("rst_data",  64'(bus.imem_data_o),  64'd0);
    check("rst_ready", 64'(bus.byte_ready_o), 64'd0);
    check("rst_start", 64'(bus.start_o),      64'd0);
    check("rst_err",   64'(bus.err_o),        64'd0);
    check("rst_words", 64'(bus.words_o),      64'd0);
    rst = 1'b1;
  endtask

  task automatic run_clear();
    int bad;
    bad = 0;
    for (int i = 0; i < 256; i++) begin
      if (!(bus.imem_we_o === 1'b1 && bus.imem_addr_o === 8'(i) &&
            bus.imem_data_o === 32'h0 && bus.byte_ready_o === 1'b0)) begin
        if (bad == 0)
          $display("first bad clear cycle %0d: we %b addr 0x%0h data 0x%0h ready %b",
                   i, bus.imem_we_o, bus.imem_addr_o, bus.imem_data_o, bus.byte_ready_o);
        bad++;
      end
      step();
    end
    check("clear_bad_cycles", 64'(bad),              64'd0);
    check("clear_then_ready", 64'(bus.byte_ready_o), 64'd1);
    check("clear_then_we",    64'(bus.imem_we_o),    64'd0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] word;
    logic [7:0]  b;

    vec[0] = '{8'h13, 8'h05, 8'h50, 8'h00, 3, 32'h00500513};
    vec[1] = '{8'hb7, 8'h12, 8'h34, 8'hfe, 0, 32'hfe3412b7};
    vec[2] = '{8'hef, 8'hbe, 8'had, 8'hde, 1, 32'hdeadbeef};
    vec[3] = '{8'hff, 8'h00, 8'hff, 8'h00, 3, 32'h00ff00ff};

    bus.byte_valid_i = 1'b0;
    bus.byte_last_i  = 1'b0;
    bus.byte_data_i  = 8'h00;

    // Reset, full clear sweep, single-word image with last
    do_reset();
    run_clear();
    send_byte(8'h13, 1'b0, 0);
    send_byte(8'h05, 1'b0, 0);
    send_byte(8'h50, 1'b0, 0);
    send_byte(8'h00, 1'b1, 0);
    check("one_we",    64'(bus.imem_we_o),    64'd1);
    check("one_addr",  64'(bus.imem_addr_o),  64'd0);
    check("one_data",  64'(bus.imem_data_o),  64'h00500513);
    check("one_words", 64'(bus.words_o),      64'd1);
    check("one_ready", 64'(bus.byte_ready_o), 64'd0);
    step();
    check("one_start",    64'(bus.start_o),      64'd1);
    check("one_we_after", 64'(bus.imem_we_o),    64'd0);
    check("one_err",      64'(bus.err_o),        64'd0);
    step();
    step();
    check("one_start_held", 64'(bus.start_o),   64'd1);
    check("one_we_held",    64'(bus.imem_we_o), 64'd0);

    // Table of words with valid gaps (last asserted with valid low during gaps)
    do_reset();
    run_clear();
    mon_en = 1'b1;
    for (int i = 0; i < 4; i++) begin
      sb_q.push_back('{addr: 8'(i), data: vec[i].exp_word});
      send_byte(vec[i].b0, 1'b0, vec[i].gap);
      send_byte(vec[i].b1, 1'b0, vec[i].gap);
      send_byte(vec[i].b2, 1'b0, vec[i].gap);
      send_byte(vec[i].b3, i == 3, vec[i].gap);
    end
    for (int i = 0; i < 4; i++) step();
    check("tab_pending", 64'(sb_q.size()),  64'd0);
    check("tab_words",   64'(bus.words_o),  64'd4);
    check("tab_start",   64'(bus.start_o),  64'd1);
    check("tab_err",     64'(bus.err_o),    64'd0);

    // Image ending mid-word
    do_reset();
    run_clear();
    mon_en = 1'b1;
    send_byte(8'haa, 1'b0, 0);
    send_byte(8'hbb, 1'b1, 0);
    check("short_err",   64'(bus.err_o),        64'd1);
    check("short_ready", 64'(bus.byte_ready_o), 64'd0);
    check("short_start", 64'(bus.start_o),      64'd0);
    check("short_we",    64'(bus.imem_we_o),    64'd0);
    for (int i = 0; i < 3; i++) step();
    check("short_err_held", 64'(bus.err_o),   64'd1);
    check("short_start_0",  64'(bus.start_o), 64'd0);
    check("short_words",    64'(bus.words_o), 64'd0);

    // Fill all 256 words back-to-back, then one byte too many
    do_reset();
    run_clear();
    mon_en = 1'b1;
    for (int w = 0; w < 256; w++) begin
      word = 32'h0;
      for (int k = 0; k < 4; k++) begin
        b = 8'($urandom_range(0, 255));
        word[8*k +: 8] = b;
        if (k == 3) sb_q.push_back('{addr: 8'(w), data: word});
        send_byte(b, 1'b0, 0);
      end
    end
    check("full_words", 64'(bus.words_o), 64'd256);
    check("full_err_0", 64'(bus.err_o),   64'd0);
    send_byte(8'h5a, 1'b0, 0);
    check("ovf_err",   64'(bus.err_o),        64'd1);
    check("ovf_ready", 64'(bus.byte_ready_o), 64'd0);
    check("ovf_start", 64'(bus.start_o),      64'd0);
    check("ovf_words", 64'(bus.words_o),      64'd256);
    step();
    step();
    check("ovf_pending", 64'(sb_q.size()), 64'd0);

    // Reset in the middle of a word
    do_reset();
    run_clear();
    mon_en = 1'b1;
    send_byte(8'h11, 1'b0, 0);
    send_byte(8'h22, 1'b0, 0);
    do_reset();
    run_clear();
    mon_en = 1'b1;
    for (int i = 0; i < 5; i++) step();
    check("mid_words", 64'(bus.words_o),      64'd0);
    check("mid_ready", 64'(bus.byte_ready_o), 64'd1);
    sb_q.push_back('{addr: 8'd0, data: 32'h11223344});
    send_byte(8'h44, 1'b0, 0);
    send_byte(8'h33, 1'b0, 0);
    send_byte(8'h22, 1'b0, 0);
    send_byte(8'h11, 1'b0, 0);
    step();
    step();
    check("mid_pending", 64'(sb_q.size()), 64'd0);
    check("mid_err",     64'(bus.err_o),   64'd0);
    mon_en = 1'b0;

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
